// File: rtl/prei_org_fifo_ctrl_pkg.sv
// prei_org_fifo_ctrl_pkg: shared sizing constants for the original-pixel FIFO controller
package prei_org_fifo_ctrl_pkg;
    localparam int PREI_ORG_ADDR_W    = 4;
    localparam int PREI_ORG_DATA_W    = 32;
    localparam int PREI_ORG_OUT_DEPTH = 2;
    localparam int PREI_ORG_OUT_CNT_W = $clog2(PREI_ORG_OUT_DEPTH + 1);
endpackage

// File: rtl/prei_fifo_skid2.sv
// prei_fifo_skid2: 2-entry in-order output stage that hides the RAM read latency
module prei_fifo_skid2
    import prei_org_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = PREI_ORG_DATA_W
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          flush,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_dat,
    input  logic                          pop,
    output logic [PREI_ORG_OUT_CNT_W-1:0] cnt,
    output logic [DATA_W-1:0]             head_dat
);
    logic [PREI_ORG_OUT_CNT_W-1:0] r_cnt;
    logic [PREI_ORG_OUT_CNT_W-1:0] w_slot;
    logic [DATA_W-1:0]             r_d0;
    logic [DATA_W-1:0]             r_d1;

    // slot the incoming word lands in once a same-cycle pop has shifted the head out
    assign w_slot   = r_cnt - PREI_ORG_OUT_CNT_W'(pop);
    assign cnt      = r_cnt;
    assign head_dat = r_d0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_d0  <= '0;
            r_d1  <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_slot + PREI_ORG_OUT_CNT_W'(push);
            r_d0  <= (push && w_slot == 0) ? push_dat : pop ? r_d1 : r_d0;
            r_d1  <= (push && w_slot == 1) ? push_dat : r_d1;
        end
    end
endmodule

// File: rtl/prei_org_fifo_ctrl.sv
// prei_org_fifo_ctrl: valid/ready FIFO controller for the 16x32 original-pixel RAM
// with a 2-entry output stage giving one word per cycle despite the 1-cycle read latency
module prei_org_fifo_ctrl
    import prei_org_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = PREI_ORG_ADDR_W,
    parameter int DATA_W = PREI_ORG_DATA_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush_i,
    input  logic              wr_val_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    output logic              wr_rdy_o,
    output logic              rd_val_o,
    output logic [DATA_W-1:0] rd_dat_o,
    input  logic              rd_rdy_i,
    output logic [4:0]        level_o,
    output logic              ram_wr_ena_o,
    output logic [ADDR_W-1:0] ram_wr_adr_o,
    output logic [DATA_W-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    output logic [ADDR_W-1:0] ram_rd_adr_o,
    input  logic [DATA_W-1:0] ram_rd_dat_i
);
    logic [ADDR_W:0]                 r_wr_ptr;
    logic [ADDR_W:0]                 r_rd_ptr;
    logic [ADDR_W:0]                 w_ram_cnt;
    logic                            r_infl;
    logic                            w_wr;
    logic                            w_iss;
    logic                            w_pop;
    logic [PREI_ORG_OUT_CNT_W-1:0]   w_out_cnt;
    logic [2:0]                      w_occ;

    assign w_ram_cnt    = r_wr_ptr - r_rd_ptr;
    // ram_cnt never exceeds the depth, so its top bit alone marks full
    assign wr_rdy_o     = !w_ram_cnt[ADDR_W];
    assign rd_val_o     = w_out_cnt != 0;
    assign w_pop        = rd_val_o && rd_rdy_i;
    assign w_wr         = wr_val_i && wr_rdy_o && !flush_i;
    assign w_occ        = 3'(w_out_cnt) + 3'(r_infl);
    assign w_iss        = !flush_i && w_ram_cnt != 0 && w_occ < 3'(PREI_ORG_OUT_DEPTH) + 3'(w_pop);
    assign level_o      = 5'(w_ram_cnt) + 5'(w_occ);
    assign ram_wr_ena_o = !w_wr;
    assign ram_wr_adr_o = r_wr_ptr[ADDR_W-1:0];
    assign ram_wr_dat_o = wr_dat_i;
    assign ram_rd_ena_o = !w_iss;
    assign ram_rd_adr_o = r_rd_ptr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_infl   <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_infl   <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(w_wr);
            r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(w_iss);
            r_infl   <= w_iss;
        end
    end

    prei_fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (flush_i),
        .push     (r_infl),
        .push_dat (ram_rd_dat_i),
        .pop      (w_pop),
        .cnt      (w_out_cnt),
        .head_dat (rd_dat_o)
    );
endmodule

// File: doc/prei_org_fifo_ctrl.md
# prei_org_fifo_ctrl

FIFO controller for the 16x32 dual-port original-pixel RAM in the pre-intra stage. It accepts 32-bit pixel words from the pixel loader through a valid/ready port and sequences the RAM's low-active write and read ports. A 2-entry output stage hides the 1-cycle RAM read latency, so the prediction engine sees a valid/ready stream with full throughput (one word per cycle). Capacity is 16 words in RAM plus 2 in the output stage.

## Interface
- `ADDR_W`, default 4: RAM address width (depth 2^ADDR_W = 16).
- `DATA_W`, default 32: word width.
- `clk` input 1: clock.
- `rstn` input 1: asynchronous, active-low reset.
- `flush_i` input 1: synchronous clear of all contents.
- `wr_val_i` input 1: loader word valid.
- `wr_dat_i` input DATA_W: loader word.
- `wr_rdy_o` output 1: controller can accept a word.
- `rd_val_o` output 1: output word valid.
- `rd_dat_o` output DATA_W: output word.
- `rd_rdy_i` input 1: consumer accepts the word.
- `level_o` output 5: total words held (RAM + in-flight + output stage), 0..18.
- `ram_wr_ena_o` output 1: RAM write enable, low active.
- `ram_wr_adr_o` output ADDR_W: RAM write address.
- `ram_wr_dat_o` output DATA_W: RAM write data (equals `wr_dat_i`).
- `ram_rd_ena_o` output 1: RAM read enable, low active.
- `ram_rd_adr_o` output ADDR_W: RAM read address.
- `ram_rd_dat_i` input DATA_W: RAM read data, valid in the cycle after `ram_rd_ena_o` is low.

## Operation
- Pointers: `wr_ptr` and `rd_ptr` are ADDR_W+1 bits wide, with an extra wrap bit. `ram_cnt = wr_ptr - rd_ptr` (modulo 2^(ADDR_W+1)). RAM is full when `ram_cnt == 16` and empty when `ram_cnt == 0`.
- Write: `wr_rdy_o = (ram_cnt != 16)`. On `wr_val_i & wr_rdy_o`:
  - `ram_wr_ena_o = 0`, `ram_wr_adr_o = wr_ptr[ADDR_W-1:0]`;
  - `wr_ptr` increments at the clock edge.
- Read issue: a RAM read is issued when `ram_cnt != 0` and `out_cnt + infl - pop < 2`, where:
  - `out_cnt` is the number of output-stage entries (0..2);
  - `infl` is 1 if a read was issued in the previous cycle;
  - `pop = rd_val_o & rd_rdy_i`.
  - On issue: `ram_rd_ena_o = 0`, `ram_rd_adr_o = rd_ptr[ADDR_W-1:0]`, and `rd_ptr` increments.
- Return: when `infl = 1`, `ram_rd_dat_i` is pushed into the output stage at the end of that cycle.
- Output stage: 2-entry in-order buffer. `rd_val_o = (out_cnt != 0)`; `rd_dat_o` is the head entry.
  - Push and pop in the same cycle are both honoured.
  - The issue rule guarantees the stage never overflows.
- Same-address hazard: `ram_cnt` comes from registered pointers, so a word is never read in the cycle it is written. No collision case exists.
- Simultaneous write and read issue: both proceed in the same cycle.
- Wrap-around: addresses wrap from 15 to 0. Full and empty are distinguished by the wrap bit.
- `level_o = ram_cnt + infl + out_cnt`, registered-state based.
- Flush: `flush_i` takes priority over same-cycle write, issue and pop. At the next edge, pointers, `out_cnt` and `infl` clear. Data returning from a read issued before the flush is discarded. In the flush cycle itself, `ram_wr_ena_o = 1` and `ram_rd_ena_o = 1`.
- Reset values:
  - `wr_ptr = rd_ptr = 0`, `out_cnt = 0`, `infl = 0`.
  - Hence `wr_rdy_o = 1`, `rd_val_o = 0`, `level_o = 0`, `ram_wr_ena_o = 1`, `ram_rd_ena_o = 1`, RAM addresses 0, `rd_dat_o = 0`.
  - Reset mid-operation drops all contents immediately (asynchronous). Writes presented while `rstn = 0` are ignored.

## Timing
- Write-to-output latency, empty FIFO:
  - word accepted at edge E0;
  - read issued in cycle E0..E1;
  - data on `ram_rd_dat_i` in E1..E2, captured at E2;
  - `rd_val_o = 1` in the cycle after E2. That is 2 cycles from acceptance to visibility.
- Steady state with `rd_rdy_i = 1` and RAM non-empty: one word per cycle out, one per cycle in.
- `wr_rdy_o` depends only on state (no combinational path from `wr_val_i`).
- `rd_val_o` depends only on state (no combinational path from `rd_rdy_i`).
- RAM enables and addresses are combinational from state, `wr_val_i`, `rd_rdy_i` and `flush_i`. They must meet RAM setup time.

## Structure
- Shared package constants: `PREI_ORG_ADDR_W = 4`, `PREI_ORG_DATA_W = 32`, `PREI_ORG_OUT_DEPTH = 2`.
- One sub-module: `prei_fifo_skid2`, the 2-entry output stage. Its interface is push, push data, pop, count, head data, and flush.
- The RAM macro is instantiated by the parent, not inside this block.

## Test plan
1. Reset, then write one word `0xA5A5_0001`. Expect:
   - one cycle with `ram_wr_ena_o = 0` at address 0;
   - next cycle `ram_rd_ena_o = 0` at address 0;
   - `rd_val_o = 1` with `rd_dat_o = 0xA5A5_0001` two cycles after acceptance;
   - `level_o` sequence 1, 1, 1, then 0 after pop.
2. Fill with `rd_rdy_i = 0` and 20 write attempts. Expect:
   - 18 accepted;
   - `wr_rdy_o = 0` with `level_o = 18` and `ram_cnt = 16`;
   - no RAM enables while full.
3. Full throughput: continuous writes 0..99 with `rd_rdy_i = 1`. Expect output 0..99 in order, one per cycle after the initial latency, with write address wrapping 15 -> 0 six times.
4. Random `rd_rdy_i` backpressure, 1000 words. Expect:
   - in-order data with no loss or duplication;
   - output stage never exceeds 2 entries;
   - never a read of an address written in the same cycle.
5. `flush_i` asserted while a read is in flight and a write is presented. Expect:
   - write ignored (`ram_wr_ena_o = 1`);
   - `level_o = 0` and `rd_val_o = 0` next cycle;
   - in-flight data discarded;
   - a following write of `0x1234_5678` is the first word out.
6. `rstn` pulsed low mid-stream with 10 words held. Expect immediate `rd_val_o = 0` and `level_o = 0`, with post-reset data starting at RAM address 0.
